// File: rtl/ddr4_cmd_issuer.sv
// ddr4_cmd_issuer: controller-side DDR4 command/address generator.
// Accepts one read/write request at a time, tracks open rows per bank, and
// sequences PRE/ACT/RD/WR with tRP/tRCD/tCCD spacing plus periodic PRA+REF.
// Command pins are decoded from registered state, so an asynchronous reset
// forces a NOP onto the bus immediately.
// Optional build macro: DDR4_AUTO_PRECHARGE_EN (closed-page policy, RDA/WRA).
module ddr4_cmd_issuer #(
    parameter int ADDRWIDTH     = 17,
    parameter int RANKS         = 1,
    parameter int BANKGROUPS    = 4,
    parameter int BANKSPERGROUP = 4,
    parameter int COLS          = 1024,
    parameter int TRCD          = 4,
    parameter int TRP           = 4,
    parameter int TCCD          = 4,
    parameter int TRFC          = 32,
    parameter int TREFI         = 1024,
    localparam int BGWIDTH      = $clog2(BANKGROUPS),
    localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
    localparam int CADDRWIDTH   = $clog2(COLS),
    localparam int RKWIDTH      = (RANKS > 1) ? $clog2(RANKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [RKWIDTH-1:0]    req_rank,
    input  logic [BGWIDTH-1:0]    req_bg,
    input  logic [BAWIDTH-1:0]    req_ba,
    input  logic [ADDRWIDTH-1:0]  req_row,
    input  logic [CADDRWIDTH-1:0] req_col,
    output logic                  cmd_done,
    output logic                  cmd_we,
    output logic                  cke,
    output logic [RANKS-1:0]      cs_n,
    output logic                  act_n,
    output logic [ADDRWIDTH-1:0]  A,
    output logic [BAWIDTH:0]      ba,
    output logic [BGWIDTH:0]      bg
);

    localparam int NBANKS = BANKGROUPS * BANKSPERGROUP;
    localparam int BIDXW  = BGWIDTH + BAWIDTH;
    localparam int TW     = 16;
    localparam int RCW    = $clog2(TREFI);

    // Command-pin encodings (A16=RAS_n, A15=CAS_n, A14=WE_n, A10=AP)
    localparam logic [ADDRWIDTH-1:0] A_NOP = ADDRWIDTH'(17'h1C000);
    localparam logic [ADDRWIDTH-1:0] A_RD  = ADDRWIDTH'(17'h14000);
    localparam logic [ADDRWIDTH-1:0] A_WR  = ADDRWIDTH'(17'h10000);
    localparam logic [ADDRWIDTH-1:0] A_PRE = ADDRWIDTH'(17'h08000);
    localparam logic [ADDRWIDTH-1:0] A_PRA = ADDRWIDTH'(17'h08400);
    localparam logic [ADDRWIDTH-1:0] A_REF = ADDRWIDTH'(17'h04000);
    localparam logic [ADDRWIDTH-1:0] A_AP  = ADDRWIDTH'(17'h00400);

    localparam logic [3:0] S_IDLE         = 4'd0;
    localparam logic [3:0] S_PRE          = 4'd1;
    localparam logic [3:0] S_WAIT_RP      = 4'd2;
    localparam logic [3:0] S_ACT          = 4'd3;
    localparam logic [3:0] S_WAIT_RCD     = 4'd4;
    localparam logic [3:0] S_CAS          = 4'd5;
    localparam logic [3:0] S_REF_PRA      = 4'd6;
    localparam logic [3:0] S_REF_WAIT_RP  = 4'd7;
    localparam logic [3:0] S_REF          = 4'd8;
    localparam logic [3:0] S_REF_WAIT_RFC = 4'd9;

    logic [3:0]            state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [TW-1:0]         ccd_q, ccd_d;
    logic [RCW-1:0]        ref_cnt_q, ref_cnt_d;
    logic                  ref_pend_q, ref_pend_d;
    logic                  cke_q, cke_d;
    logic                  init_q, init_d;
    logic                  cur_we_q, cur_we_d;
    logic [RKWIDTH-1:0]    cur_rank_q, cur_rank_d;
    logic [BGWIDTH-1:0]    cur_bg_q, cur_bg_d;
    logic [BAWIDTH-1:0]    cur_ba_q, cur_ba_d;
    logic [ADDRWIDTH-1:0]  cur_row_q, cur_row_d;
    logic [CADDRWIDTH-1:0] cur_col_q, cur_col_d;
    logic [NBANKS-1:0]     open_q, open_d;
    logic [ADDRWIDTH-1:0]  row_tab_q [NBANKS];
    logic [ADDRWIDTH-1:0]  row_tab_d [NBANKS];

    logic [BIDXW-1:0]      cur_idx;
    logic [BIDXW-1:0]      req_idx;
    logic                  act_ok;
    logic                  ref_ok;
    logic                  cas_ok;
    logic [RANKS-1:0]      rank_sel_n;

    assign cur_idx    = {cur_bg_q, cur_ba_q};
    assign req_idx    = {req_bg, req_ba};
    assign cas_ok     = (ccd_q == '0);
    assign rank_sel_n = ~(RANKS'(1) << cur_rank_q);
    assign cke        = cke_q;
    assign req_ready  = (state_q == S_IDLE) && init_q && !ref_pend_q;

`ifdef DDR4_AUTO_PRECHARGE_EN
    logic [TW-1:0]    ap_cnt_q, ap_cnt_d;
    logic [BIDXW-1:0] ap_bank_q, ap_bank_d;

    // An auto-precharged bank needs tRP before it can be activated again;
    // refresh waits for any such precharge to complete.
    assign act_ok = !((ap_cnt_q != '0) && (ap_bank_q == cur_idx));
    assign ref_ok = (ap_cnt_q == '0);
`else
    assign act_ok = 1'b1;
    assign ref_ok = 1'b1;
`endif

    // Next-state, timers, refresh scheduling and bank-table updates
    always_comb begin
        state_d    = state_q;
        timer_d    = (timer_q != '0) ? timer_q - TW'(1) : '0;
        ccd_d      = (ccd_q != '0) ? ccd_q - TW'(1) : '0;
        ref_pend_d = ref_pend_q;
        cke_d      = 1'b1;
        init_d     = cke_q;
        cur_we_d   = cur_we_q;
        cur_rank_d = cur_rank_q;
        cur_bg_d   = cur_bg_q;
        cur_ba_d   = cur_ba_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        open_d     = open_q;
        for (int i = 0; i < NBANKS; i++) begin
            row_tab_d[i] = row_tab_q[i];
        end
`ifdef DDR4_AUTO_PRECHARGE_EN
        ap_cnt_d  = (ap_cnt_q != '0) ? ap_cnt_q - TW'(1) : '0;
        ap_bank_d = ap_bank_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (init_q && ref_pend_q) begin
                    ref_pend_d = 1'b0;
                    state_d    = (|open_q) ? S_REF_PRA : S_REF;
                end else if (req_ready && req_valid) begin
                    cur_we_d   = req_we;
                    cur_rank_d = req_rank;
                    cur_bg_d   = req_bg;
                    cur_ba_d   = req_ba;
                    cur_row_d  = req_row;
                    cur_col_d  = req_col;
`ifdef DDR4_AUTO_PRECHARGE_EN
                    state_d = S_ACT;
`else
                    if (!open_q[req_idx])
                        state_d = S_ACT;
                    else if (row_tab_q[req_idx] == req_row)
                        state_d = S_CAS;
                    else
                        state_d = S_PRE;
`endif
                end
            end
            S_PRE: begin
                open_d[cur_idx] = 1'b0;
                timer_d         = TW'(TRP - 2);
                state_d         = (TRP <= 1) ? S_ACT : S_WAIT_RP;
            end
            S_WAIT_RP: begin
                if (timer_q == '0) state_d = S_ACT;
            end
            S_ACT: begin
                if (act_ok) begin
                    open_d[cur_idx]    = 1'b1;
                    row_tab_d[cur_idx] = cur_row_q;
                    timer_d            = TW'(TRCD - 2);
                    state_d            = (TRCD <= 1) ? S_CAS : S_WAIT_RCD;
                end
            end
            S_WAIT_RCD: begin
                if (timer_q == '0) state_d = S_CAS;
            end
            S_CAS: begin
                if (cas_ok) begin
                    ccd_d   = TW'(TCCD - 1);
                    state_d = S_IDLE;
`ifdef DDR4_AUTO_PRECHARGE_EN
                    open_d[cur_idx] = 1'b0;
                    ap_cnt_d        = TW'(TRP - 1);
                    ap_bank_d       = cur_idx;
`endif
                end
            end
            S_REF_PRA: begin
                timer_d = TW'(TRP - 2);
                state_d = (TRP <= 1) ? S_REF : S_REF_WAIT_RP;
            end
            S_REF_WAIT_RP: begin
                if (timer_q == '0) state_d = S_REF;
            end
            S_REF: begin
                if (ref_ok) begin
                    open_d  = '0;
                    timer_d = TW'(TRFC - 2);
                    state_d = (TRFC <= 1) ? S_IDLE : S_REF_WAIT_RFC;
                end
            end
            S_REF_WAIT_RFC: begin
                if (timer_q == '0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Free-running refresh interval counter; set after any service clear
        if (ref_cnt_q == RCW'(TREFI - 1)) begin
            ref_cnt_d  = '0;
            ref_pend_d = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q + RCW'(1);
        end
    end

    // Command/address pin decode from the registered state
    always_comb begin
        cs_n     = '1;
        act_n    = 1'b1;
        A        = A_NOP;
        ba       = '0;
        bg       = '0;
        cmd_done = 1'b0;
        cmd_we   = 1'b0;
        case (state_q)
            S_PRE: begin
                cs_n = rank_sel_n;
                A    = A_PRE;
                ba   = {1'b0, cur_ba_q};
                bg   = {1'b0, cur_bg_q};
            end
            S_ACT: begin
                if (act_ok) begin
                    cs_n  = rank_sel_n;
                    act_n = 1'b0;
                    A     = cur_row_q;
                    ba    = {1'b0, cur_ba_q};
                    bg    = {1'b0, cur_bg_q};
                end
            end
            S_CAS: begin
                if (cas_ok) begin
                    cs_n     = rank_sel_n;
                    A        = (cur_we_q ? A_WR : A_RD) | ADDRWIDTH'(cur_col_q);
`ifdef DDR4_AUTO_PRECHARGE_EN
                    A        = A | A_AP;
`endif
                    ba       = {1'b0, cur_ba_q};
                    bg       = {1'b0, cur_bg_q};
                    cmd_done = 1'b1;
                    cmd_we   = cur_we_q;
                end
            end
            S_REF_PRA: begin
                cs_n = '0;
                A    = A_PRA;
            end
            S_REF: begin
                if (ref_ok) begin
                    cs_n = '0;
                    A    = A_REF;
                end
            end
            default: ;
        endcase
    end

    // Control state with asynchronous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            ccd_q      <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            cke_q      <= 1'b0;
            init_q     <= 1'b0;
            cur_we_q   <= 1'b0;
            cur_rank_q <= '0;
            cur_bg_q   <= '0;
            cur_ba_q   <= '0;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            open_q     <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ccd_q      <= ccd_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            cke_q      <= cke_d;
            init_q     <= init_d;
            cur_we_q   <= cur_we_d;
            cur_rank_q <= cur_rank_d;
            cur_bg_q   <= cur_bg_d;
            cur_ba_q   <= cur_ba_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            open_q     <= open_d;
        end
    end

    // Open-row table; contents are only meaningful while the open flag is set
    always_ff @(posedge clk) begin
        for (int i = 0; i < NBANKS; i++) begin
            row_tab_q[i] <= row_tab_d[i];
        end
    end

`ifdef DDR4_AUTO_PRECHARGE_EN
    // Auto-precharge recovery tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ap_cnt_q  <= '0;
            ap_bank_q <= '0;
        end else begin
            ap_cnt_q  <= ap_cnt_d;
            ap_bank_q <= ap_bank_d;
        end
    end
`endif

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// tb_ddr4_cmd_issuer: directed test of ddr4_cmd_issuer with default parameters
// (TRCD=TRP=TCCD=4, TRFC=32, TREFI=1024). Expected values are hand-computed.
module tb_ddr4_cmd_issuer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [0:0]  req_rank = '0;
    logic [1:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [16:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        cmd_done;
    logic        cmd_we;
    logic        cke;
    logic [0:0]  cs_n;
    logic        act_n;
    logic [16:0] A;
    logic [2:0]  ba;
    logic [2:0]  bg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ddr4_cmd_issuer dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_rank  (req_rank),
        .req_bg    (req_bg),
        .req_ba    (req_ba),
        .req_row   (req_row),
        .req_col   (req_col),
        .cmd_done  (cmd_done),
        .cmd_we    (cmd_we),
        .cke       (cke),
        .cs_n      (cs_n),
        .act_n     (act_n),
        .A         (A),
        .ba        (ba),
        .bg        (bg)
    );

    always #5 clk = ~clk;

    // Posedges since reset release
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for ready, and step past the accept edge
    task automatic issue(input logic we, input logic [1:0] g, input logic [1:0] b,
                         input logic [16:0] row, input logic [9:0] col);
        int n;
        req_we = we; req_bg = g; req_ba = b; req_row = row; req_col = col;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 64) begin
            tick();
            n++;
        end
        check("issue_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
    endtask

    // Watch the bus until cmd_done, noting first ACT and first PRE cycles
    task automatic wait_cmd(output int done_cyc, output int act_cyc, output int pre_cyc,
                            output int done_a, output int done_we);
        done_cyc = -1; act_cyc = -1; pre_cyc = -1; done_a = 0; done_we = 0;
        for (int n = 0; n < 64; n++) begin
            if (!act_n && act_cyc < 0) act_cyc = cyc;
            if (!cs_n[0] && A == 17'h08000 && pre_cyc < 0) pre_cyc = cyc;
            if (cmd_done) begin
                done_cyc = cyc;
                done_a   = int'(A);
                done_we  = int'(cmd_we);
                break;
            end
            tick();
        end
        check("cmd_done_seen", {31'd0, done_cyc >= 0}, 32'd1);
    endtask

    initial begin
        int t0, dc, ac, pc, da, dw, prev_rd, ref_cyc, n, saw;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", cs_n, 1);
        check("rst_act_n", act_n, 1);
        check("rst_A", A, 32'h1C000);
        check("rst_cke", cke, 0);
        check("rst_ready", req_ready, 0);
        check("rst_done", cmd_done, 0);
        check("rst_ba_bg", {ba, bg}, 0);
        reset_n = 1'b1;
        #1;
        check("rel_cke_low", cke, 0);
        tick();
        check("cke_first_edge", cke, 1);
        check("ready_first_edge", req_ready, 0);
        tick();
        check("ready_second_edge", req_ready, 1);

        // Read from a closed bank: ACT then RD tRCD later
        issue(1'b0, 2'd1, 2'd2, 17'h00123, 10'h040);
        t0 = cyc;
        check("t1_act_n", act_n, 0);
        check("t1_act_A", A, 32'h00123);
        check("t1_act_bg", bg, 1);
        check("t1_act_ba", ba, 2);
        check("t1_act_cs", cs_n, 0);
        tick();
        check("t1_gap_nop", A, 32'h1C000);
        wait_cmd(dc, ac, pc, da, dw);
        check("t1_trcd", dc - t0, 4);
        check("t1_rd_A", da, 32'h14040);
        check("t1_cmd_we", dw, 0);
        $display("txn rd bg=1 ba=2 row=0x123 col=0x040 act@%0d rd@%0d", t0, dc);
        prev_rd = dc;
        tick();
        check("ready_after_cas", req_ready, 1);

        // Row hit: no ACT, RD exactly tCCD after the previous RD
        issue(1'b0, 2'd1, 2'd2, 17'h00123, 10'h048);
        check("t2_no_act_at_accept", act_n, 1);
        wait_cmd(dc, ac, pc, da, dw);
        check("t2_no_act", ac, -1);
        check("t2_tccd", dc - prev_rd, 4);
        check("t2_rd_A", da, 32'h14048);
        $display("txn rd hit col=0x048 rd@%0d", dc);
        tick();

        // Row miss write: PRE, ACT tRP later, WR tRCD after that
        issue(1'b1, 2'd1, 2'd2, 17'h00200, 10'h010);
        t0 = cyc;
        check("t3_pre_A", A, 32'h08000);
        check("t3_pre_bg_ba", {bg, ba}, {3'd1, 3'd2});
        wait_cmd(dc, ac, pc, da, dw);
        check("t3_pre_cyc", pc, t0);
        check("t3_trp", ac - pc, 4);
        check("t3_trcd", dc - ac, 4);
        check("t3_wr_A", da, 32'h10010);
        check("t3_cmd_we", dw, 1);
        $display("txn wr miss row=0x200 col=0x010 pre@%0d act@%0d wr@%0d", pc, ac, dc);
        tick();

        // Refresh with a bank open and a request waiting
        while (cyc < 1023) tick();
        check("ready_before_refi", req_ready, 1);
        tick();
        req_we = 1'b0; req_bg = 2'd1; req_ba = 2'd2; req_row = 17'h00200; req_col = 10'h020;
        req_valid = 1'b1;
        #1;
        check("ready_refresh_pending", req_ready, 0);
        tick();
        t0 = cyc;
        check("pra_A", A, 32'h08400);
        check("pra_cs", cs_n, 0);
        check("pra_act_n", act_n, 1);
        ref_cyc = -1;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (!cs_n[0] && A == 17'h04000) begin
                ref_cyc = cyc;
                break;
            end
        end
        check("pra_to_ref", ref_cyc - t0, 4);
        n = 0;
        saw = 0;
        while (!req_ready && n < 64) begin
            tick();
            if (!act_n || cmd_done) saw = 1;
            n++;
        end
        check("trfc_ready", cyc - ref_cyc, 32);
        check("quiet_during_rfc", saw, 0);
        tick();
        req_valid = 1'b0;
        check("act_after_ref", act_n, 0);
        check("act_after_ref_A", A, 32'h00200);
        wait_cmd(dc, ac, pc, da, dw);
        check("rd_after_ref_A", da, 32'h14020);
        $display("txn refresh pra@%0d ref@%0d, rd after ref@%0d", t0, ref_cyc, dc);
        tick();

        // Reset dropped during WAIT_RCD
        issue(1'b0, 2'd0, 2'd0, 17'h00055, 10'h001);
        check("t5_act", act_n, 0);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_A", A, 32'h1C000);
        check("async_rst_cs", cs_n, 1);
        check("async_rst_act_n", act_n, 1);
        check("async_rst_cke", cke, 0);
        saw = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cmd_done || !cs_n[0]) saw = 1;
        end
        check("no_cmd_in_reset", saw, 0);
        reset_n = 1'b1;
        tick();
        tick();
        issue(1'b0, 2'd1, 2'd2, 17'h00200, 10'h030);
        check("act_after_reset", act_n, 0);
        wait_cmd(dc, ac, pc, da, dw);
        check("rd_after_reset_A", da, 32'h14030);
        $display("txn reset mid-op, then rd bg=1 ba=2 row=0x200 rd@%0d", dc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
